toeplitz_row_gen: RTL
=====================

# toeplitz_row_gen

Parametrised Toeplitz-matrix row generator for the privacy-amplification hash datapath. It loads one seed through a valid/ready handshake and emits ROWS_PER_BURST × NUM_BURSTS matrix rows. Each row is an ROW_W-bit window of the seed, advanced by one bit per accepted row. Rows are delivered in bursts separated by a fixed gap, with per-row backpressure, burst/frame framing and abort, feeding the downstream row-times-key accumulator.

## Interface
- ROW_W, 3072: row width in bits.
- SEED_W, 7168: seed register width in bits.
- ROWS_PER_BURST, 32: rows per burst; ≥1.
- NUM_BURSTS, 128: bursts per frame; ≥1.
- GAP_CYC, 2: idle cycles before each burst; ≥0.
- clk_in  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed  input  SEED_W  seed value, sampled on handshake.
- seed_valid  input  1  seed offered.
- seed_ready  output  1  high only in IDLE.
- abort  input  1  synchronous frame abort.
- row_data  output  ROW_W  current row, seed_cache[SEED_W-1 -: ROW_W].
- row_valid  output  1  row_data valid (RUN only).
- row_ready  input  1  downstream accepts row.
- row_last  output  1  row_valid on last row of a burst.
- burst_start  output  1  row_valid on first row of a burst.
- frame_done  output  1  one-cycle pulse after the frame's final row handshake.

## Operation
- States: IDLE, GAP, RUN, DONE. All are held in toeplitz_pkg.
- IDLE: seed_ready=1. seed_valid&seed_ready → seed_cache<=seed, row_cnt<=0, burst_cnt<=0, gap_cnt<=0, → GAP.
- GAP: gap_cnt counts to GAP_CYC, then → RUN. GAP_CYC=0 → RUN on the next cycle.
- RUN: row_valid=1. On row_valid&row_ready, seed_cache shifts left by 1 (zero fill) and row_cnt++.
  - On the handshake of row ROWS_PER_BURST-1, row_cnt<=0 and burst_cnt++.
  - Then → GAP, or → DONE if it was burst NUM_BURSTS-1.
- DONE: frame_done=1 for one cycle, → IDLE.
- Frame row k (k = b·ROWS_PER_BURST + r) = seed[SEED_W-1-k -: ROW_W].
- Elaboration check (without rotate): SEED_W ≥ ROW_W + ROWS_PER_BURST·NUM_BURSTS − 1, else $error.
- Counters: row_cnt is $clog2(ROWS_PER_BURST) bits (min 1); burst_cnt is $clog2(NUM_BURSTS+1) bits.
- seed_valid outside IDLE is ignored and no seed is captured.
- abort (any non-IDLE state) → IDLE next cycle; counters cleared; seed_cache cleared; no frame_done.
  - If abort coincides with a RUN handshake, that row counts as transferred; abort still wins the state transition.
- abort in IDLE has no effect. abort and seed_valid in IDLE in the same cycle: the seed is accepted.
- row_ready is ignored when row_valid=0.

## Timing
- Reset (rst_n=0, async): state=IDLE, seed_cache=0, counters=0.
  - seed_ready=1 (decoded from IDLE); row_data=0; row_valid, row_last, burst_start, frame_done=0.
- row_valid, row_last, burst_start, seed_ready and frame_done are combinational decodes of registered state/counters.
- row_data is a direct slice of the register; it is stable while row_valid&!row_ready.
- Seed handshake at edge t → first row_valid in cycle t+1+GAP_CYC.
- With continuous ready, one row per cycle within a burst. Each inter-burst gap is GAP_CYC cycles.
- frame_done is asserted in the cycle after the final row handshake. seed_ready returns the cycle after that.

## Configuration
- TRG_ROTATE_EN defined: seed_cache rotates left (MSB wraps into LSB) instead of zero-fill.
  - Elaboration check relaxes to SEED_W ≥ ROW_W; rows are cyclic windows of the seed.
- Undefined: zero-fill shift plus the full-length elaboration check above.

## Structure
- toeplitz_pkg:
  - state enum trg_state_e {IDLE, GAP, RUN, DONE}.
  - Default width constants TRG_ROW_W=3072, TRG_SEED_W=7168.
- One sub-module, trg_seed_shreg:
  - SEED_W register with load, shift-enable and clear.
  - TRG_ROTATE_EN selects the fill bit.
  - It exposes the top ROW_W window.
- FSM and counters live in toeplitz_row_gen.

## Test plan
- ROW_W=8, SEED_W=16, ROWS_PER_BURST=4, NUM_BURSTS=2, GAP_CYC=2; seed 16'hA5C3, row_ready=1 → rows A5,4B,97,2E | 5C,B8,70,E1.
  - burst_start on A5 and 5C; row_last on 2E and E1.
  - First row at t+3; 2-cycle gap between bursts; frame_done one cycle after E1.
- Same config, row_ready low for 3 cycles while 97 is presented → row_data holds 97, row_valid stays 1, no advance; next row 2E after ready returns.
- TRG_ROTATE_EN, ROW_W=8, SEED_W=8, ROWS_PER_BURST=4, NUM_BURSTS=2, seed 8'h81 → rows 81,03,06,0C,18,30,60,C0.
  - The same config without the macro fails elaboration.
- abort asserted during second row of burst 0 → IDLE next cycle, seed_ready=1, row_valid=0, no frame_done; a new seed restarts from row 0.
- rst_n pulled low mid-RUN, asynchronous to clk_in → row_valid=0, row_data=0 immediately; seed_ready=1.
- seed_valid held high with a different seed during RUN → ignored; output rows match the originally captured seed.

Source files
------------

// File: rtl/toeplitz_pkg.sv
// rtl/toeplitz_pkg.sv - shared states, default widths and sizing helper for the Toeplitz row generator
package toeplitz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } trg_state_e;

  localparam int TRG_ROW_W  = 3072;
  localparam int TRG_SEED_W = 7168;

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int trg_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trg_seed_shreg.sv
// rtl/trg_seed_shreg.sv - seed shift register exposing the top ROW_W window; TRG_ROTATE_EN selects wrap-around fill
module trg_seed_shreg #(
  parameter int SEED_W = 16,
  parameter int ROW_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [SEED_W-1:0] i_load_data,
  input  logic              i_shift_en,
  input  logic              i_clear,
  output logic [ROW_W-1:0]  o_window
);

  logic [SEED_W-1:0] r_q;
  logic              w_fill;

`ifdef TRG_ROTATE_EN
  assign w_fill = r_q[SEED_W-1];
`else
  assign w_fill = 1'b0;
`endif

  // Clear outranks shift so an abort on a handshake still empties the window
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift_en) begin
      r_q <= {r_q[SEED_W-2:0], w_fill};
    end
  end

  assign o_window = r_q[SEED_W-1 -: ROW_W];

endmodule

// File: rtl/toeplitz_row_gen.sv
// rtl/toeplitz_row_gen.sv - Toeplitz row generator: seed handshake, bursted row stream, abort; TRG_ROTATE_EN enables cyclic rows
module toeplitz_row_gen
  import toeplitz_pkg::*;
#(
  parameter int ROW_W          = TRG_ROW_W,
  parameter int SEED_W         = TRG_SEED_W,
  parameter int ROWS_PER_BURST = 32,
  parameter int NUM_BURSTS     = 128,
  parameter int GAP_CYC        = 2
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [SEED_W-1:0] seed,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              abort,
  output logic [ROW_W-1:0]  row_data,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              row_last,
  output logic              burst_start,
  output logic              frame_done
);

  localparam int RCW      = trg_cnt_w(ROWS_PER_BURST);
  localparam int BCW      = trg_cnt_w(NUM_BURSTS + 1);
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int GCW      = trg_cnt_w(GAP_LAST + 1);

  localparam logic [RCW-1:0] ROW_END   = RCW'(ROWS_PER_BURST - 1);
  localparam logic [BCW-1:0] BURST_END = BCW'(NUM_BURSTS - 1);
  localparam logic [GCW-1:0] GAP_END   = GCW'(GAP_LAST);

  generate
`ifdef TRG_ROTATE_EN
    if (SEED_W < ROW_W) begin : g_size_chk
      $error("toeplitz_row_gen: SEED_W must be at least ROW_W");
    end
`else
    if (SEED_W < ROW_W + ROWS_PER_BURST * NUM_BURSTS - 1) begin : g_size_chk
      $error("toeplitz_row_gen: SEED_W too short for a full zero-fill frame");
    end
`endif
    if (ROWS_PER_BURST < 1 || NUM_BURSTS < 1 || GAP_CYC < 0) begin : g_param_chk
      $error("toeplitz_row_gen: illegal burst geometry");
    end
  endgenerate

  trg_state_e     r_state;
  trg_state_e     w_state_nxt;
  logic [RCW-1:0] r_row_cnt;
  logic [RCW-1:0] w_row_cnt_nxt;
  logic [BCW-1:0] r_burst_cnt;
  logic [BCW-1:0] w_burst_cnt_nxt;
  logic [GCW-1:0] r_gap_cnt;
  logic [GCW-1:0] w_gap_cnt_nxt;
  logic           w_load;
  logic           w_shift;
  logic           w_clear;
  logic           w_row_hs;

  assign w_row_hs = (r_state == RUN) && row_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_burst_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_cnt   <= w_row_cnt_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_cnt_nxt   = r_row_cnt;
    w_burst_cnt_nxt = r_burst_cnt;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_clear         = 1'b0;

    case (r_state)
      IDLE: begin
        if (seed_valid) begin
          w_load          = 1'b1;
          w_row_cnt_nxt   = '0;
          w_burst_cnt_nxt = '0;
          w_gap_cnt_nxt   = '0;
          w_state_nxt     = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_END) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = RUN;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GCW'(1);
        end
      end
      RUN: begin
        if (w_row_hs) begin
          w_shift = 1'b1;
          if (r_row_cnt == ROW_END) begin
            w_row_cnt_nxt   = '0;
            w_burst_cnt_nxt = r_burst_cnt + BCW'(1);
            w_gap_cnt_nxt   = '0;
            w_state_nxt     = (r_burst_cnt == BURST_END) ? DONE : GAP;
          end else begin
            w_row_cnt_nxt = r_row_cnt + RCW'(1);
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Abort overrides whatever the state decided, including a same-cycle row handshake
    if (abort && (r_state != IDLE)) begin
      w_state_nxt     = IDLE;
      w_row_cnt_nxt   = '0;
      w_burst_cnt_nxt = '0;
      w_gap_cnt_nxt   = '0;
      w_clear         = 1'b1;
    end
  end

  trg_seed_shreg #(
    .SEED_W (SEED_W),
    .ROW_W  (ROW_W)
  ) u_shreg (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_load_data (seed),
    .i_shift_en  (w_shift),
    .i_clear     (w_clear),
    .o_window    (row_data)
  );

  assign seed_ready  = (r_state == IDLE);
  assign row_valid   = (r_state == RUN);
  assign row_last    = (r_state == RUN) && (r_row_cnt == ROW_END);
  assign burst_start = (r_state == RUN) && (r_row_cnt == '0);
  assign frame_done  = (r_state == DONE);

endmodule
